// File: rtl/sort4_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sort4_ctrl_pkg
// Description : Shared types and default constants for the 4-word sort
//               controller: FSM state encoding, sorter tag record and
//               default sizing constants.
// Revision    : 1.0 - initial release
// ============================================================================
package sort4_ctrl_pkg;

   localparam int DEF_WIDTH      = 32;
   localparam int DEF_SORT_LAT   = 4;
   localparam int DEF_FIFO_DEPTH = 4;

   // Beat sequencer: IDLE waits for a grant, B0 sends words 0/1, B1 words 2/3.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      B0   = 2'd1,
      B1   = 2'd2
   } state_t;

   // Travels alongside a quad through the external sorter pipeline.
   typedef struct packed {
      logic valid;
      logic id;
   } tag_t;

endpackage
`default_nettype wire

// File: rtl/sort4_res_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sort4_res_fifo
// Description : First-word-fall-through result FIFO. Push and pop in the
//               same cycle are accepted at any occupancy, including full.
//               Read data is forced to zero while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module sort4_res_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic [DW-1:0] data_i,
   input  logic          pop_i,
   output logic          valid_o,
   output logic [DW-1:0] data_o,
   output logic [CW-1:0] count_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [CW-1:0] cnt_q;
   logic          do_push;
   logic          do_pop;

   assign valid_o = (cnt_q != '0);
   assign do_pop  = pop_i & valid_o;
   // A full FIFO can still take a word when the head leaves in the same cycle.
   assign do_push = push_i & ((cnt_q != CW'(DEPTH)) | do_pop);
   assign data_o  = valid_o ? mem_q[rd_q] : '0;
   assign count_o = cnt_q;

   // Storage write; contents are don't-care until the count covers them.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_q] <= data_i;
      end
   end

   // Pointer and occupancy bookkeeping with wrap for non-power-of-two depths.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            wr_q <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
         end
         if (do_pop) begin
            rd_q <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
         end
         if (do_push && !do_pop) begin
            cnt_q <= cnt_q + CW'(1);
         end else if (!do_push && do_pop) begin
            cnt_q <= cnt_q - CW'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sort4_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sort4_ctrl
// Description : Arbitrates two quad requesters round-robin, feeds each quad
//               to an external pipelined 4-word sorter in two beats, tracks
//               the sorter latency with a tag shift register and queues the
//               sorted results in an FWFT FIFO. Credits bound the number of
//               quads in flight so the FIFO never overflows.
// Revision    : 1.0 - initial release
// ============================================================================
module sort4_ctrl
   import sort4_ctrl_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int SORT_LAT   = DEF_SORT_LAT,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req0_valid,
   input  logic               req1_valid,
   output logic               req0_ready,
   output logic               req1_ready,
   input  logic [4*WIDTH-1:0] req0_data,
   input  logic [4*WIDTH-1:0] req1_data,
   output logic [WIDTH-1:0]   srt_a,
   output logic [WIDTH-1:0]   srt_b,
   output logic               srt_sel,
   input  logic [WIDTH-1:0]   srt_maxf,
   input  logic [WIDTH-1:0]   srt_medh,
   input  logic [WIDTH-1:0]   srt_medl,
   input  logic [WIDTH-1:0]   srt_minf,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_id,
   output logic [WIDTH-1:0]   out_max,
   output logic [WIDTH-1:0]   out_medh,
   output logic [WIDTH-1:0]   out_medl,
   output logic [WIDTH-1:0]   out_min
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int SUM_W = CNT_W + 1;
   localparam int ENT_W = 4 * WIDTH + 1;

   state_t             state_q;
   state_t             state_d;
   logic [4*WIDTH-1:0] hold_q;
   logic               hold_id_q;
   logic               last_q;
   tag_t               tag_q [SORT_LAT];
   tag_t               tag_in;
   tag_t               tag_out;
   logic [CNT_W-1:0]   infl_q;
   logic [CNT_W-1:0]   fifo_cnt;
   logic [SUM_W-1:0]   pend;
   logic               credit_ok;
   logic               issue;
   logic               gnt_id;
   logic [ENT_W-1:0]   fifo_wdata;
   logic [ENT_W-1:0]   fifo_rdata;

   // The quad sitting in the hold register during B1 is not yet counted as
   // in flight, so it is added here to keep exactly FIFO_DEPTH quads owed.
   assign pend      = SUM_W'(infl_q) + SUM_W'(fifo_cnt) + SUM_W'(state_q == B1);
   assign credit_ok = (pend < SUM_W'(FIFO_DEPTH));
   assign tag_in    = {(state_q == B1), hold_id_q};
   assign tag_out   = tag_q[SORT_LAT-1];

   // Grant, beat sequencing and sorter operand selection.
   always_comb begin
      state_d    = state_q;
      srt_a      = '0;
      srt_b      = '0;
      srt_sel    = 1'b0;
      gnt_id     = (req0_valid & req1_valid) ? ~last_q : req1_valid;
      // Ready stays low while reset is held even though the FSM sits in IDLE.
      issue      = rst & credit_ok & (req0_valid | req1_valid)
                   & ((state_q == IDLE) | (state_q == B1));
      case (state_q)
         IDLE: begin
            state_d = issue ? B0 : IDLE;
         end
         B0: begin
            srt_a   = hold_q[0*WIDTH +: WIDTH];
            srt_b   = hold_q[1*WIDTH +: WIDTH];
            state_d = B1;
         end
         B1: begin
            srt_a   = hold_q[2*WIDTH +: WIDTH];
            srt_b   = hold_q[3*WIDTH +: WIDTH];
            srt_sel = 1'b1;
            state_d = issue ? B0 : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      req0_ready = issue & ~gnt_id;
      req1_ready = issue & gnt_id;
   end

   // FSM state, quad hold register and round-robin pointer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         hold_q    <= '0;
         hold_id_q <= 1'b0;
         last_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         if (issue) begin
            hold_q    <= gnt_id ? req1_data : req0_data;
            hold_id_q <= gnt_id;
            last_q    <= gnt_id;
         end
      end
   end

   // Tag pipeline mirroring the sorter latency; bubbles carry valid=0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SORT_LAT; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         tag_q[0] <= tag_in;
         for (int i = 1; i < SORT_LAT; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   // In-flight count: up on a B1 push, down when a tag leaves the pipeline.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         infl_q <= '0;
      end else if (tag_in.valid && !tag_out.valid) begin
         infl_q <= infl_q + CNT_W'(1);
      end else if (!tag_in.valid && tag_out.valid) begin
         infl_q <= infl_q - CNT_W'(1);
      end
   end

   assign fifo_wdata = {tag_out.id, srt_maxf, srt_medh, srt_medl, srt_minf};

   sort4_res_fifo #(
      .DW    (ENT_W),
      .DEPTH (FIFO_DEPTH),
      .CW    (CNT_W)
   ) u_res_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (tag_out.valid),
      .data_i  (fifo_wdata),
      .pop_i   (out_ready),
      .valid_o (out_valid),
      .data_o  (fifo_rdata),
      .count_o (fifo_cnt)
   );

   assign out_id   = fifo_rdata[4*WIDTH];
   assign out_max  = fifo_rdata[3*WIDTH +: WIDTH];
   assign out_medh = fifo_rdata[2*WIDTH +: WIDTH];
   assign out_medl = fifo_rdata[1*WIDTH +: WIDTH];
   assign out_min  = fifo_rdata[0*WIDTH +: WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_sort4_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sort4_ctrl
// Description : Scoreboard bench for sort4_ctrl with a behavioural external
//               sorter whose result pipeline lines up with the tag register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sort4_ctrl;

   localparam int W = 32;
   localparam int L = 4;
   localparam int D = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           req0_valid, req1_valid, req0_ready, req1_ready;
   logic [4*W-1:0] req0_data, req1_data;
   logic [W-1:0]   srt_a, srt_b;
   logic           srt_sel;
   logic [W-1:0]   srt_maxf, srt_medh, srt_medl, srt_minf;
   logic           out_valid, out_ready, out_id;
   logic [W-1:0]   out_max, out_medh, out_medl, out_min;

   typedef struct packed { logic [W-1:0] mx, mh, ml, mn; } res_t;
   typedef struct { logic id; res_t r; bit chk_lat; int acc_cyc; } exp_t;

   int             nchecks = 0;
   int             nerrors = 0;
   int             cyc = 0;
   logic [4*W-1:0] src0 [$];
   logic [4*W-1:0] src1 [$];
   exp_t           e0 [$];
   exp_t           e1 [$];
   exp_t           sb [$];
   int             acc_ids [$];
   int             acc_cyc [$];

   sort4_ctrl #(.WIDTH(W), .SORT_LAT(L), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_data(req0_data), .req1_data(req1_data),
      .srt_a(srt_a), .srt_b(srt_b), .srt_sel(srt_sel),
      .srt_maxf(srt_maxf), .srt_medh(srt_medh), .srt_medl(srt_medl), .srt_minf(srt_minf),
      .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
      .out_max(out_max), .out_medh(out_medh), .out_medl(out_medl), .out_min(out_min)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input bit ok, input string name, input string detail);
      nchecks++;
      if (!ok) begin
         nerrors++;
         $display("FAIL %s: %s", name, detail);
      end
   endtask

   // ---------------- behavioural external sorter ----------------
   function automatic res_t sort4(input logic [W-1:0] a, b, c, d);
      logic [W-1:0] v [4];
      logic [W-1:0] t;
      res_t r;
      v[0] = a; v[1] = b; v[2] = c; v[3] = d;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3 - i; j++)
            if (v[j] < v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
      r.mx = v[0]; r.mh = v[1]; r.ml = v[2]; r.mn = v[3];
      return r;
   endfunction

   logic [W-1:0] s_a = '0, s_b = '0, p_a = '0, p_b = '0;
   logic         s_sel = 1'b0;
   res_t         pipe [L];

   always @(negedge clk) begin
      s_a = srt_a; s_b = srt_b; s_sel = srt_sel;
   end

   // Words 0/1 are captured on the beat before sel=1; the sel=1 edge loads
   // the sorted quad, which reaches the outputs L-1 edges later.
   always @(posedge clk) begin
      pipe[0] <= s_sel ? sort4(p_a, p_b, s_a, s_b) : '0;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      if (!s_sel) begin p_a <= s_a; p_b <= s_b; end
   end

   assign srt_maxf = pipe[L-1].mx;
   assign srt_medh = pipe[L-1].mh;
   assign srt_medl = pipe[L-1].ml;
   assign srt_minf = pipe[L-1].mn;

   // ---------------- requester feeders ----------------
   initial begin
      req0_valid = 1'b0; req0_data = '0;
      req1_valid = 1'b0; req1_data = '0;
      forever begin
         @(posedge clk); #1;
         if (src0.size() > 0) begin req0_valid = 1'b1; req0_data = src0[0]; end
         else begin req0_valid = 1'b0; req0_data = '0; end
         if (src1.size() > 0) begin req1_valid = 1'b1; req1_data = src1[0]; end
         else begin req1_valid = 1'b0; req1_data = '0; end
      end
   end

   // Accept monitor: every handshake pushes its expectation onto the scoreboard.
   exp_t ea;
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (req0_valid && req0_ready && src0.size() > 0) begin
            ea = e0.pop_front(); void'(src0.pop_front());
            ea.acc_cyc = cyc; sb.push_back(ea);
            acc_ids.push_back(0); acc_cyc.push_back(cyc);
         end
         if (req1_valid && req1_ready && src1.size() > 0) begin
            ea = e1.pop_front(); void'(src1.pop_front());
            ea.acc_cyc = cyc; sb.push_back(ea);
            acc_ids.push_back(1); acc_cyc.push_back(cyc);
         end
      end
   end

   // Output monitor: pops and compares on each transfer, checks stall stability.
   exp_t         eo;
   logic         stall_q = 1'b0;
   logic         pid;
   logic [W-1:0] pm, ph, pl, pn;
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q)
            check(out_valid && {out_id, out_max, out_medh, out_medl, out_min} == {pid, pm, ph, pl, pn},
                  "stall_hold", $sformatf("got v=%0b id=%0d %h %h %h %h, held id=%0d %h %h %h %h",
                  out_valid, out_id, out_max, out_medh, out_medl, out_min, pid, pm, ph, pl, pn));
         if (out_valid) begin
            if (sb.size() == 0) begin
               check(1'b0, "unexpected_out", $sformatf("got out_valid with id=%0d max=%h, required no output",
                     out_id, out_max));
            end else if (out_ready) begin
               eo = sb.pop_front();
               check({out_id, out_max, out_medh, out_medl, out_min} == {eo.id, eo.r},
                     "result", $sformatf("got id=%0d %h %h %h %h, required id=%0d %h %h %h %h",
                     out_id, out_max, out_medh, out_medl, out_min, eo.id, eo.r.mx, eo.r.mh, eo.r.ml, eo.r.mn));
               if (eo.chk_lat)
                  check(cyc - eo.acc_cyc == L + 3, "latency",
                        $sformatf("got %0d cycles, required %0d", cyc - eo.acc_cyc, L + 3));
            end
         end
         stall_q = out_valid && !out_ready;
         pid = out_id; pm = out_max; ph = out_medh; pl = out_medl; pn = out_min;
      end
   end

   // ---------------- helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic send(input int id, input logic [W-1:0] w0, w1, w2, w3,
                       input logic [W-1:0] mx, mh, ml, mn, input bit lat);
      exp_t e;
      e.id = id[0]; e.r.mx = mx; e.r.mh = mh; e.r.ml = ml; e.r.mn = mn;
      e.chk_lat = lat; e.acc_cyc = 0;
      if (id == 0) begin src0.push_back({w3, w2, w1, w0}); e0.push_back(e); end
      else begin src1.push_back({w3, w2, w1, w0}); e1.push_back(e); end
   endtask

   task automatic drain(input string name, input int maxc);
      int n = 0;
      while ((sb.size() > 0 || src0.size() > 0 || src1.size() > 0 || out_valid) && n < maxc) begin
         tick(1); n++;
      end
      check(n < maxc, name, $sformatf("drain needed %0d cycles, limit %0d", n, maxc));
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      src0.delete(); e0.delete(); src1.delete(); e1.delete(); sb.delete();
      #1;
      check(!out_valid && !req0_ready && !req1_ready && !srt_sel && srt_a == '0 && srt_b == '0,
            "rst_async", $sformatf("got v=%0b r0=%0b r1=%0b sel=%0b a=%h b=%h, required all 0",
            out_valid, req0_ready, req1_ready, srt_sel, srt_a, srt_b));
      tick(n);
      rst = 1'b1;
      tick(1);
   endtask

   int exp_gnt [4] = '{0, 1, 0, 1};
   int nv;

   // ---------------- directed sequence ----------------
   initial begin
      rst = 1'b0; out_ready = 1'b1;
      tick(3);
      @(negedge clk);
      check(out_max == '0 && out_medh == '0 && out_medl == '0 && out_min == '0 && out_id == 1'b0,
            "rst_out_data", $sformatf("got %h %h %h %h id=%0d, required 0", out_max, out_medh, out_medl, out_min, out_id));
      @(posedge clk); #2; rst = 1'b1;
      tick(2);
      @(negedge clk);
      check(out_valid == 1'b0, "rel_out_valid", $sformatf("got %0b, required 0", out_valid));
      check(!req0_ready && !req1_ready, "rel_ready", $sformatf("got %0b/%0b, required 0/0", req0_ready, req1_ready));
      check(srt_sel == 1'b0, "rel_srt_sel", $sformatf("got %0b, required 0", srt_sel));
      @(posedge clk); #2;

      // Single quad with latency check.
      send(0, 5, 9, 1, 7, 9, 7, 5, 1, 1'b1);
      drain("drain_single", 40);

      // Contention: fresh pointer, both requesters loaded at once.
      do_reset(2);
      acc_ids.delete(); acc_cyc.delete();
      send(0, 3, 1, 4, 2, 4, 3, 2, 1, 1'b0);
      send(1, 10, 20, 30, 40, 40, 30, 20, 10, 1'b0);
      send(0, 7, 7, 2, 9, 9, 7, 7, 2, 1'b0);
      send(1, 100, 50, 75, 25, 100, 75, 50, 25, 1'b0);
      drain("drain_contention", 60);
      check(acc_ids.size() == 4, "cont_grants", $sformatf("got %0d grants, required 4", acc_ids.size()));
      if (acc_ids.size() == 4) begin
         for (int i = 0; i < 4; i++)
            check(acc_ids[i] == exp_gnt[i], "cont_order", $sformatf("grant %0d got id %0d, required %0d", i, acc_ids[i], exp_gnt[i]));
         for (int i = 1; i < 4; i++)
            check(acc_cyc[i] - acc_cyc[i-1] == 2, "cont_spacing",
                  $sformatf("grant %0d spacing got %0d, required 2", i, acc_cyc[i] - acc_cyc[i-1]));
      end

      // Backpressure: only FIFO_DEPTH quads may be accepted while stalled.
      acc_ids.delete(); acc_cyc.delete();
      out_ready = 1'b0;
      send(0, 1, 2, 3, 4, 4, 3, 2, 1, 1'b0);
      send(0, 8, 6, 7, 5, 8, 7, 6, 5, 1'b0);
      send(0, 0, 0, 0, 1, 1, 0, 0, 0, 1'b0);
      send(0, 12, 11, 10, 9, 12, 11, 10, 9, 1'b0);
      send(0, 2, 2, 2, 2, 2, 2, 2, 2, 1'b0);
      send(0, 32'h8000_0000, 32'h7FFF_FFFF, 1, 32'hFFFF_FFFE,
           32'hFFFF_FFFE, 32'h8000_0000, 32'h7FFF_FFFF, 1, 1'b0);
      tick(30);
      check(acc_ids.size() == D, "bp_accepts", $sformatf("got %0d accepts, required %0d", acc_ids.size(), D));
      @(negedge clk);
      check(out_valid && !req0_ready, "bp_stalled", $sformatf("got out_valid=%0b req0_ready=%0b, required 1/0", out_valid, req0_ready));
      @(posedge clk); #2;
      out_ready = 1'b1;
      drain("drain_bp", 80);
      check(acc_ids.size() == 6, "bp_resume", $sformatf("got %0d accepts, required 6", acc_ids.size()));

      // Duplicates and extremes.
      send(1, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b1);
      drain("drain_extreme", 40);

      // Mid-flight reset drops the quad in the sorter pipeline.
      acc_ids.delete(); acc_cyc.delete();
      send(0, 11, 22, 33, 44, 44, 33, 22, 11, 1'b0);
      nv = 0;
      while (acc_ids.size() == 0 && nv < 20) begin tick(1); nv++; end
      check(acc_ids.size() == 1, "mf_accept", $sformatf("got %0d accepts, required 1", acc_ids.size()));
      tick(2);
      do_reset(3);
      nv = 0;
      repeat (20) begin @(negedge clk); if (out_valid) nv++; end
      check(nv == 0, "mf_no_output", $sformatf("got %0d out_valid cycles, required 0", nv));
      @(posedge clk); #2;
      send(0, 6, 2, 8, 4, 8, 6, 4, 2, 1'b1);
      drain("drain_after_rst", 40);

      check(sb.size() == 0, "sb_empty", $sformatf("got %0d pending, required 0", sb.size()));
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
